// File: rtl/scratchpad_mem_arbiter_pkg.sv
// Shared sizes, FSM state encoding and requester identifiers for the
// scratchpad / core memory-port arbiter.
package scratchpad_mem_arbiter_pkg;

    localparam int WORD_W       = 32;
    localparam int MATRIX_W     = 4;
    localparam int VALUE_BITS   = 16;
    localparam int BITS_PER_ROW = MATRIX_W * VALUE_BITS;
    localparam int ROW_S_W      = $clog2(MATRIX_W);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CORE = 3'd1,
        LD0  = 3'd2,
        LD1  = 3'd3,
        ST0  = 3'd4,
        ST1  = 3'd5,
        DONE = 3'd6
    } arb_state_t;

    // Encoding doubles as the bit position in the request / grant vectors.
    typedef enum logic [1:0] {
        REQ_CORE = 2'd0,
        REQ_LD   = 2'd1,
        REQ_ST   = 2'd2
    } requester_t;

    function automatic requester_t onehot_to_req(input logic [2:0] grant);
        requester_t who;
        who = REQ_CORE;
        if (grant[1]) begin
            who = REQ_LD;
        end else if (grant[2]) begin
            who = REQ_ST;
        end
        return who;
    endfunction

endpackage

// File: rtl/scratchpad_mem_arbiter_rr_select3.sv
// Three-way rotating-priority picker: the search starts at the requester
// after the one granted last, so nobody is granted twice while another waits.
module rr_select3
    import scratchpad_mem_arbiter_pkg::*;
(
    input  logic [2:0] req_i,
    input  requester_t last_i,
    output logic [2:0] grant_o
);

    always_comb begin
        grant_o = 3'b000;
        case (last_i)
            REQ_LD: begin
                if (req_i[2]) begin
                    grant_o = 3'b100;
                end else if (req_i[0]) begin
                    grant_o = 3'b001;
                end else if (req_i[1]) begin
                    grant_o = 3'b010;
                end
            end
            REQ_ST: begin
                if (req_i[0]) begin
                    grant_o = 3'b001;
                end else if (req_i[1]) begin
                    grant_o = 3'b010;
                end else if (req_i[2]) begin
                    grant_o = 3'b100;
                end
            end
            default: begin
                if (req_i[1]) begin
                    grant_o = 3'b010;
                end else if (req_i[2]) begin
                    grant_o = 3'b100;
                end else if (req_i[0]) begin
                    grant_o = 3'b001;
                end
            end
        endcase
    end

endmodule

// File: rtl/scratchpad_mem_arbiter.sv
// Shares one 32-bit memory port between scratchpad row loads, row stores and
// the core data port; rows move as two word beats, loads carry a row index.
module scratchpad_mem_arbiter
    import scratchpad_mem_arbiter_pkg::*;
(
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    sLoad,
    input  logic [WORD_W-1:0]       load_addr,
    input  logic                    sStore,
    input  logic [WORD_W-1:0]       store_addr,
    input  logic [BITS_PER_ROW-1:0] store_data,
    output logic [BITS_PER_ROW-1:0] load_data,
    output logic                    sLoad_hit,
    output logic                    sStore_hit,
    output logic [ROW_S_W-1:0]      sLoad_row,
    input  logic                    dmem_ren,
    input  logic                    dmem_wen,
    input  logic [WORD_W-1:0]       dmem_addr,
    input  logic [WORD_W-1:0]       dmem_wdata,
    output logic [WORD_W-1:0]       dmem_rdata,
    output logic                    dmem_hit,
    output logic                    ram_ren,
    output logic                    ram_wen,
    output logic [WORD_W-1:0]       ram_addr,
    output logic [WORD_W-1:0]       ram_wdata,
    input  logic [WORD_W-1:0]       ram_rdata,
    input  logic                    ram_ready
);

    arb_state_t              state_q, state_d;
    requester_t              gnt_q, gnt_d;
    logic                    core_wr_q, core_wr_d;
    logic [WORD_W-1:0]       low_q, low_d;
    logic [BITS_PER_ROW-1:0] load_data_q, load_data_d;
    logic [WORD_W-1:0]       dmem_rdata_q, dmem_rdata_d;
    logic [ROW_S_W-1:0]      row_q, row_d;

    logic [2:0]              req_vec;
    logic [2:0]              grant;
    logic [WORD_W-1:0]       addr_sel;

    assign req_vec = {sStore, sLoad, dmem_ren | dmem_wen};

    rr_select3 u_rr (
        .req_i   (req_vec),
        .last_i  (gnt_q),
        .grant_o (grant)
    );

    // The core direction is frozen at grant so a dropped request still finishes.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        core_wr_d    = core_wr_q;
        low_d        = low_q;
        load_data_d  = load_data_q;
        dmem_rdata_d = dmem_rdata_q;
        row_d        = row_q;
        case (state_q)
            IDLE: begin
                if (grant != 3'b000) begin
                    gnt_d     = onehot_to_req(grant);
                    core_wr_d = dmem_wen;
                    case (onehot_to_req(grant))
                        REQ_LD:  state_d = LD0;
                        REQ_ST:  state_d = ST0;
                        default: state_d = CORE;
                    endcase
                end
            end
            CORE: begin
                if (ram_ready) begin
                    dmem_rdata_d = ram_rdata;
                    state_d      = DONE;
                end
            end
            LD0: begin
                if (ram_ready) begin
                    low_d   = ram_rdata;
                    state_d = LD1;
                end
            end
            LD1: begin
                if (ram_ready) begin
                    load_data_d = {ram_rdata, low_q};
                    state_d     = DONE;
                end
            end
            ST0: begin
                if (ram_ready) begin
                    state_d = ST1;
                end
            end
            ST1: begin
                if (ram_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (gnt_q == REQ_LD) begin
                    row_d = (row_q == ROW_S_W'(MATRIX_W - 1)) ? '0 : row_q + 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            gnt_q        <= REQ_CORE;
            core_wr_q    <= 1'b0;
            low_q        <= '0;
            load_data_q  <= '0;
            dmem_rdata_q <= '0;
            row_q        <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            core_wr_q    <= core_wr_d;
            low_q        <= low_d;
            load_data_q  <= load_data_d;
            dmem_rdata_q <= dmem_rdata_d;
            row_q        <= row_d;
        end
    end

    // Addresses and store data come straight from the requester every beat.
    always_comb begin
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        addr_sel  = '0;
        ram_wdata = '0;
        case (state_q)
            CORE: begin
                ram_ren   = ~core_wr_q;
                ram_wen   = core_wr_q;
                addr_sel  = dmem_addr;
                ram_wdata = core_wr_q ? dmem_wdata : '0;
            end
            LD0: begin
                ram_ren  = 1'b1;
                addr_sel = load_addr;
            end
            LD1: begin
                ram_ren  = 1'b1;
                addr_sel = load_addr + WORD_W'(4);
            end
            ST0: begin
                ram_wen   = 1'b1;
                addr_sel  = store_addr;
                ram_wdata = store_data[WORD_W-1:0];
            end
            ST1: begin
                ram_wen   = 1'b1;
                addr_sel  = store_addr + WORD_W'(4);
                ram_wdata = store_data[BITS_PER_ROW-1:WORD_W];
            end
            default: begin
                ram_ren = 1'b0;
            end
        endcase
    end

    assign ram_addr   = {addr_sel[WORD_W-1:2], 2'b00};

    assign sLoad_hit  = (state_q == DONE) && (gnt_q == REQ_LD);
    assign sStore_hit = (state_q == DONE) && (gnt_q == REQ_ST);
    assign dmem_hit   = (state_q == DONE) && (gnt_q == REQ_CORE);

    assign load_data  = load_data_q;
    assign dmem_rdata = dmem_rdata_q;
    assign sLoad_row  = row_q;

endmodule

// File: tb/tb_scratchpad_mem_arbiter.sv
// Directed self-checking bench for scratchpad_mem_arbiter: a word memory model
// with programmable wait states and a hit monitor feed immediate assertions.
module tb_scratchpad_mem_arbiter;
    import scratchpad_mem_arbiter_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic        sLoad, sStore, dmem_ren, dmem_wen;
    logic [31:0] load_addr, store_addr, dmem_addr, dmem_wdata;
    logic [63:0] store_data, load_data;
    logic        sLoad_hit, sStore_hit, dmem_hit;
    logic [1:0]  sLoad_row;
    logic [31:0] dmem_rdata, ram_addr, ram_wdata, ram_rdata;
    logic        ram_ren, ram_wen, ram_ready;

    int          testsRun = 0;
    int          testsFailed = 0;

    logic [31:0] mem [0:1023];
    bit          memValid [0:1023];
    int          writeBeats = 0;
    int          strobeClash = 0;
    int          hitOrder [$];
    logic [1:0]  hitRows [$];

    logic        waitMode = 1'b0;
    logic        readyVal = 1'b1;
    int          waitCnt = 0;

    scratchpad_mem_arbiter dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .sLoad      (sLoad),
        .load_addr  (load_addr),
        .sStore     (sStore),
        .store_addr (store_addr),
        .store_data (store_data),
        .load_data  (load_data),
        .sLoad_hit  (sLoad_hit),
        .sStore_hit (sStore_hit),
        .sLoad_row  (sLoad_row),
        .dmem_ren   (dmem_ren),
        .dmem_wen   (dmem_wen),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_hit   (dmem_hit),
        .ram_ren    (ram_ren),
        .ram_wen    (ram_wen),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .ram_ready  (ram_ready)
    );

    always #5 CLK = ~CLK;

    // Unwritten words read back a fixed preload pattern.
    function automatic logic [31:0] preload(input logic [31:0] a);
        logic [31:0] v;
        case (a)
            32'h100: v = 32'hAAAA0001;
            32'h104: v = 32'hBBBB0002;
            default: v = {16'hC0DE, a[15:0]};
        endcase
        return v;
    endfunction

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return memValid[a[11:2]] ? mem[a[11:2]] : preload({a[31:2], 2'b00});
    endfunction

    assign ram_rdata = memValid[ram_addr[11:2]] ? mem[ram_addr[11:2]]
                                                : preload({ram_addr[31:2], 2'b00});
    assign ram_ready = waitMode ? (waitCnt == 2) : readyVal;

    // In wait mode each beat is held off for two cycles before ready.
    always @(posedge CLK) begin
        if ((ram_ren || ram_wen) && !ram_ready) begin
            waitCnt <= waitCnt + 1;
        end else begin
            waitCnt <= 0;
        end
    end

    // Memory writes and completion pulses are sampled mid-cycle.
    always @(negedge CLK) begin
        if (nRST) begin
            if (ram_wen && ram_ready) begin
                mem[ram_addr[11:2]] = ram_wdata;
                memValid[ram_addr[11:2]] = 1'b1;
                writeBeats++;
            end
            if (ram_ren && ram_wen) strobeClash++;
            if (sLoad_hit) begin
                hitOrder.push_back(1);
                hitRows.push_back(sLoad_row);
            end
            if (sStore_hit) hitOrder.push_back(2);
            if (dmem_hit) hitOrder.push_back(0);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic ld, input logic st, input logic ren, input logic wen);
        sLoad    = ld;
        sStore   = st;
        dmem_ren = ren;
        dmem_wen = wen;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int h0, w0, hr0;
        logic [1:0] expRows [5];
        int expOrder [6];
        expRows  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        expOrder = '{1, 2, 0, 1, 2, 0};

        applyStimulus(0, 0, 0, 0);
        load_addr = 32'h100; store_addr = 32'h200; store_data = '0;
        dmem_addr = '0; dmem_wdata = '0;
        #1 nRST = 1'b0;
        #1;
        checkOutput("reset_strobes_hits", {ram_ren, ram_wen, sLoad_hit, sStore_hit, dmem_hit}, 5'b0);
        checkOutput("reset_load_data", load_data, 64'h0);
        checkOutput("reset_rdata_row", {dmem_rdata, sLoad_row}, 34'h0);
        tick(2);
        nRST = 1'b1;
        tick(1);

        // Single row load, ready tied high.
        load_addr = 32'h100;
        applyStimulus(1, 0, 0, 0);
        tick(1);
        checkOutput("ld_beat0", {ram_ren, ram_wen, sLoad_hit, ram_addr}, {3'b100, 32'h100});
        tick(1);
        checkOutput("ld_beat1", {ram_ren, sLoad_hit, ram_addr}, {2'b10, 32'h104});
        tick(1);
        checkOutput("ld_hit", {sLoad_hit, sLoad_row}, {1'b1, 2'd0});
        checkOutput("ld_data", load_data, 64'hBBBB0002_AAAA0001);
        applyStimulus(0, 0, 0, 0);
        tick(1);
        checkOutput("ld_hit_end_row", {sLoad_hit, sLoad_row}, {1'b0, 2'd1});

        // Core read and write together: write wins, address aligned down.
        w0 = writeBeats;
        dmem_addr = 32'h7; dmem_wdata = 32'hDEADBEEF;
        applyStimulus(0, 0, 1, 1);
        tick(1);
        checkOutput("core_wr_beat", {ram_ren, ram_wen, ram_addr, ram_wdata}, {2'b01, 32'h4, 32'hDEADBEEF});
        tick(1);
        checkOutput("core_wr_hit", dmem_hit, 1'b1);
        applyStimulus(0, 0, 0, 0);
        tick(1);
        checkOutput("core_wr_single", {dmem_hit, 32'(writeBeats - w0)}, {1'b0, 32'd1});
        checkOutput("core_wr_mem", memWord(32'h4), 32'hDEADBEEF);

        // Core read.
        dmem_addr = 32'h104;
        applyStimulus(0, 0, 1, 0);
        tick(1);
        checkOutput("core_rd_beat", {ram_ren, ram_wen, ram_addr}, {2'b10, 32'h104});
        tick(1);
        checkOutput("core_rd_hit", {dmem_hit, dmem_rdata}, {1'b1, 32'hBBBB0002});
        applyStimulus(0, 0, 0, 0);
        tick(1);
        checkOutput("load_data_hold", load_data, 64'hBBBB0002_AAAA0001);

        // Row store with two wait cycles per beat.
        waitMode = 1'b1;
        store_addr = 32'h200; store_data = 64'h11112222_33334444;
        h0 = hitOrder.size();
        applyStimulus(0, 1, 0, 0);
        tick(1);
        checkOutput("st_beat0", {ram_wen, ram_ready, ram_addr, ram_wdata}, {2'b10, 32'h200, 32'h33334444});
        tick(2);
        checkOutput("st_beat0_held", {ram_wen, sStore_hit, ram_addr}, {2'b10, 32'h200});
        tick(1);
        checkOutput("st_beat1", {ram_wen, ram_ready, ram_addr, ram_wdata}, {2'b10, 32'h204, 32'h11112222});
        tick(3);
        checkOutput("st_hit", sStore_hit, 1'b1);
        applyStimulus(0, 0, 0, 0);
        tick(1);
        checkOutput("st_hit_single", {sStore_hit, 32'(hitOrder.size() - h0)}, {1'b0, 32'd1});
        checkOutput("st_mem", {memWord(32'h200), memWord(32'h204)}, 64'h33334444_11112222);
        waitMode = 1'b0;

        // Reset while the second load beat is stalled.
        load_addr = 32'h100;
        h0 = hitOrder.size();
        applyStimulus(1, 0, 0, 0);
        tick(2);
        readyVal = 1'b0;
        tick(3);
        checkOutput("ld1_stalled", {ram_ren, sLoad_hit, ram_addr}, {2'b10, 32'h104});
        #2 nRST = 1'b0;
        #1;
        checkOutput("rst_mid_strobes", {ram_ren, ram_wen, sLoad_hit, sStore_hit, dmem_hit}, 5'b0);
        checkOutput("rst_mid_data", {load_data, dmem_rdata, sLoad_row}, 98'h0);
        tick(2);
        checkOutput("rst_mid_no_hit", 32'(hitOrder.size() - h0), 32'd0);
        readyVal = 1'b1;
        hr0 = hitRows.size();
        nRST = 1'b1;
        tick(1);
        checkOutput("post_rst_ld0", {ram_ren, ram_addr, sLoad_row}, {1'b1, 32'h100, 2'd0});

        // Back-to-back loads: row index wraps after MATRIX_W hits.
        for (int c = 0; c < 60 && hitRows.size() < hr0 + 5; c++) tick(1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("five_loads_done", hitRows.size() >= hr0 + 5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("row_seq_%0d", i), hitRows[hr0 + i], expRows[i]);
        end
        tick(6);

        // Contention from reset: all three requesters held high.
        nRST = 1'b0;
        dmem_addr = 32'h100; store_addr = 32'h300;
        applyStimulus(1, 1, 1, 0);
        tick(1);
        h0 = hitOrder.size();
        nRST = 1'b1;
        for (int c = 0; c < 100 && hitOrder.size() < h0 + 6; c++) tick(1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("contention_done", hitOrder.size() >= h0 + 6, 1'b1);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("grant_order_%0d", i), 32'(hitOrder[h0 + i]), 32'(expOrder[i]));
        end
        checkOutput("one_strobe_only", 32'(strobeClash), 32'd0);
        tick(6);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
